if_stage: RTL

//  Instruction-fetch stage of the pipelined CPU: holds the fetch PC, talks to instruction memory over a
//  req/gnt/rvalid handshake with variable latency, and loads the IF/ID pipeline register.

---
 rtl/if_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/gnt/rvalid handshake
// and loads the IF/ID pipeline register, with stall holding and redirect squashing.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00003000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_fetch,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pcFetch_q, pcFetch_d;
  logic        idValid_q, idValid_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic [31:0] idPc4_q, idPc4_d;
  logic [31:0] holdInstr_q, holdInstr_d;
  logic [31:0] holdPc4_q, holdPc4_d;

  logic        redirEff;
  logic [31:0] pcPlus4;

  assign redirEff = redirect && !stall;
  assign pcPlus4  = pcFetch_q + 32'd4;

  // Any unstalled cycle that does not load IF/ID presents a bubble, so ID never sees a word twice.
  always_comb begin
    state_d     = state_q;
    pcFetch_d   = pcFetch_q;
    idValid_d   = idValid_q;
    idInstr_d   = idInstr_q;
    idPc4_d     = idPc4_q;
    holdInstr_d = holdInstr_q;
    holdPc4_d   = holdPc4_q;

    if (!stall) begin
      idValid_d = 1'b0;
      idInstr_d = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d = redirEff ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirEff) begin
            state_d = S_REQ;
          end else if (stall) begin
            holdInstr_d = imem_rdata;
            holdPc4_d   = pcPlus4;
            state_d     = S_HOLD;
          end else begin
            idValid_d = 1'b1;
            idInstr_d = imem_rdata;
            idPc4_d   = pcPlus4;
            pcFetch_d = next_pc;
            state_d   = S_REQ;
          end
        end else if (redirEff) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (!redirEff) begin
            idValid_d = 1'b1;
            idInstr_d = holdInstr_q;
            idPc4_d   = holdPc4_q;
            pcFetch_d = next_pc;
          end
          state_d = S_REQ;
        end
      end
      default: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
    endcase

    // Redirect wins over every row above; the bubble was already set since stall is low.
    if (redirEff) begin
      pcFetch_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pcFetch_q   <= RESET_PC;
      idValid_q   <= 1'b0;
      idInstr_q   <= NOP_INSTR;
      idPc4_q     <= 32'd0;
      holdInstr_q <= 32'd0;
      holdPc4_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pcFetch_q   <= pcFetch_d;
      idValid_q   <= idValid_d;
      idInstr_q   <= idInstr_d;
      idPc4_q     <= idPc4_d;
      holdInstr_q <= holdInstr_d;
      holdPc4_q   <= holdPc4_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = pcFetch_q;
  assign pc_fetch  = pcFetch_q;
  assign id_valid  = idValid_q;
  assign id_instr  = idInstr_q;
  assign id_pc4    = idPc4_q;

endmodule
